// File: rtl/core_pkg.sv
// Opcode encodings and instruction-field helpers shared by the pipelined core.
// Field helpers work on a zero-extended word so they serve any parameterisation.
package core_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_MOVI = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_SLLI = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_BEQZ = 3'b111;

   localparam int unsigned FIELD_W = 64;
   typedef logic [FIELD_W-1:0] field_t;

   function automatic field_t low_mask(input int unsigned w);
      return (field_t'(1) << w) - field_t'(1);
   endfunction

   // Layout MSB to LSB: {opcode[2:0], rd, rs, imm}.
   function automatic logic [2:0] get_op(input field_t instr, input int unsigned reg_aw,
                                         input int unsigned imm_w);
      return 3'((instr >> (2 * reg_aw + imm_w)) & field_t'(7));
   endfunction

   function automatic field_t get_rd(input field_t instr, input int unsigned reg_aw,
                                     input int unsigned imm_w);
      return (instr >> (reg_aw + imm_w)) & low_mask(reg_aw);
   endfunction

   function automatic field_t get_rs(input field_t instr, input int unsigned reg_aw,
                                     input int unsigned imm_w);
      return (instr >> imm_w) & low_mask(reg_aw);
   endfunction

   function automatic field_t get_imm(input field_t instr, input int unsigned imm_w);
      return instr & low_mask(imm_w);
   endfunction

   function automatic logic reg_write(input logic [2:0] op);
      return op inside {OP_MOVI, OP_ADD, OP_SUB, OP_AND, OP_SLLI};
   endfunction

   function automatic logic is_branch(input logic [2:0] op);
      return op inside {OP_JMP, OP_BEQZ};
   endfunction

endpackage

// File: rtl/core_regfile.sv
// Register file: synchronous reset, one write port, two asynchronous read ports.
// A write in progress is passed straight through to a matching read.
module core_regfile #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o
);

   localparam int unsigned NUM_REGS = 2 ** REG_AW;

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
      rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
   end

endmodule

// File: rtl/param_pipelined_core.sv
// Four-stage IF/ID/EX/WB core with EX/WB forwarding, branch flush, external stall
// and a retirement trace port driven from the EX/WB registers.
module param_pipelined_core #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned REG_AW = 3,
   parameter int unsigned IMM_W  = 8,
   parameter int unsigned PC_W   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        stall,
   output logic [PC_W-1:0]             imem_addr,
   input  logic [3+2*REG_AW+IMM_W-1:0] imem_data,
   output logic                        retire_valid,
   output logic [PC_W-1:0]             retire_pc,
   output logic                        retire_we,
   output logic [REG_AW-1:0]           retire_rd,
   output logic [DATA_W-1:0]           retire_data
);

   import core_pkg::*;

   localparam int unsigned INSTR_W = 3 + 2 * REG_AW + IMM_W;
   localparam int unsigned SH_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [PC_W-1:0]    pc_q;

   logic               ifid_valid_q;
   logic [INSTR_W-1:0] ifid_instr_q;
   logic [PC_W-1:0]    ifid_pc_q;

   logic               idex_valid_q;
   logic [2:0]         idex_op_q;
   logic [REG_AW-1:0]  idex_rd_q;
   logic [REG_AW-1:0]  idex_rs_q;
   logic [IMM_W-1:0]   idex_imm_q;
   logic [PC_W-1:0]    idex_pc_q;
   logic [DATA_W-1:0]  idex_rd_val_q;
   logic [DATA_W-1:0]  idex_rs_val_q;

   logic               exwb_valid_q;
   logic               exwb_we_q;
   logic [REG_AW-1:0]  exwb_rd_q;
   logic [DATA_W-1:0]  exwb_data_q;
   logic [PC_W-1:0]    exwb_pc_q;

   field_t             id_word;
   logic [2:0]         id_op;
   logic [REG_AW-1:0]  id_rd;
   logic [REG_AW-1:0]  id_rs;
   logic [IMM_W-1:0]   id_imm;
   logic [DATA_W-1:0]  id_rd_val;
   logic [DATA_W-1:0]  id_rs_val;

   logic               wb_write;

   logic               fwd_a;
   logic               fwd_b;
   logic [DATA_W-1:0]  ex_a;
   logic [DATA_W-1:0]  ex_b;
   logic [DATA_W-1:0]  ex_result;
   logic               ex_we;
   logic               ex_taken;
   logic [PC_W-1:0]    ex_target;

   // ID: field decode and register read.
   always_comb begin
      id_word                = '0;
      id_word[INSTR_W-1:0]   = ifid_instr_q;
      id_op                  = get_op(id_word, REG_AW, IMM_W);
      id_rd                  = REG_AW'(get_rd(id_word, REG_AW, IMM_W));
      id_rs                  = REG_AW'(get_rs(id_word, REG_AW, IMM_W));
      id_imm                 = IMM_W'(get_imm(id_word, IMM_W));
   end

   // WB writes are suppressed while stalled so a held instruction writes exactly once.
   assign wb_write = exwb_valid_q & exwb_we_q & ~stall;

   core_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk_i     (clk),
      .reset_i   (reset),
      .we_i      (wb_write),
      .waddr_i   (exwb_rd_q),
      .wdata_i   (exwb_data_q),
      .raddr_a_i (id_rd),
      .rdata_a_o (id_rd_val),
      .raddr_b_i (id_rs),
      .rdata_b_o (id_rs_val)
   );

   // EX: operand forwarding from EX/WB, ALU and branch resolution.
   always_comb begin
      fwd_a     = exwb_valid_q & exwb_we_q & (exwb_rd_q == idex_rd_q);
      fwd_b     = exwb_valid_q & exwb_we_q & (exwb_rd_q == idex_rs_q);
      ex_a      = fwd_a ? exwb_data_q : idex_rd_val_q;
      ex_b      = fwd_b ? exwb_data_q : idex_rs_val_q;
      ex_result = '0;
      ex_we     = idex_valid_q & reg_write(idex_op_q);
      ex_target = PC_W'(idex_imm_q);
      ex_taken  = idex_valid_q & is_branch(idex_op_q) &
                  ((idex_op_q == OP_JMP) | (ex_a == '0));
      case (idex_op_q)
         OP_MOVI: ex_result = DATA_W'(idex_imm_q);
         OP_ADD:  ex_result = ex_a + ex_b;
         OP_SUB:  ex_result = ex_a - ex_b;
         OP_AND:  ex_result = ex_a & ex_b;
         OP_SLLI: ex_result = ex_a << idex_imm_q[SH_W-1:0];
         default: ex_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= '0;
         ifid_valid_q  <= 1'b0;
         ifid_instr_q  <= '0;
         ifid_pc_q     <= '0;
         idex_valid_q  <= 1'b0;
         idex_op_q     <= OP_NOP;
         idex_rd_q     <= '0;
         idex_rs_q     <= '0;
         idex_imm_q    <= '0;
         idex_pc_q     <= '0;
         idex_rd_val_q <= '0;
         idex_rs_val_q <= '0;
         exwb_valid_q  <= 1'b0;
         exwb_we_q     <= 1'b0;
         exwb_rd_q     <= '0;
         exwb_data_q   <= '0;
         exwb_pc_q     <= '0;
      end else if (!stall) begin
         pc_q          <= ex_taken ? ex_target : pc_q + PC_W'(1);
         // A taken branch squashes the two younger instructions behind it.
         ifid_valid_q  <= ~ex_taken;
         ifid_instr_q  <= imem_data;
         ifid_pc_q     <= pc_q;
         idex_valid_q  <= ifid_valid_q & ~ex_taken;
         idex_op_q     <= id_op;
         idex_rd_q     <= id_rd;
         idex_rs_q     <= id_rs;
         idex_imm_q    <= id_imm;
         idex_pc_q     <= ifid_pc_q;
         idex_rd_val_q <= id_rd_val;
         idex_rs_val_q <= id_rs_val;
         exwb_valid_q  <= idex_valid_q;
         exwb_we_q     <= ex_we;
         exwb_rd_q     <= idex_rd_q;
         exwb_data_q   <= ex_result;
         exwb_pc_q     <= idex_pc_q;
      end
   end

   assign imem_addr    = pc_q;
   assign retire_valid = exwb_valid_q & ~stall;
   assign retire_pc    = exwb_pc_q;
   assign retire_we    = exwb_we_q;
   assign retire_rd    = exwb_rd_q;
   assign retire_data  = exwb_data_q;

endmodule
